if_fetch_queue: RTL and testbench

IF_FETCH_QUEUE -- requirements
Module: if_fetch_queue

---
 rtl/if_fetch_queue.sv | 140 ++++++++++++++
 tb/tb_if_fetch_queue.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_queue.sv
// Instruction fetch unit with a small in-order queue of fetched words, one outstanding request,
// and redirect handling. Define IF_QUEUE_BYPASS_EN to present a response on the cycle it arrives when the queue is empty.
module if_fetch_queue #(
   parameter logic [31:0] RESET_VECTOR = 32'h60000000,
   parameter int          QUEUE_DEPTH  = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_redirect,
   input  logic [31:0] i_redirect_pc,
   input  logic        id_stall,
   output logic [31:0] imem_addr,
   output logic [3:0]  imem_rmask,
   input  logic        imem_resp,
   input  logic [31:0] imem_rdata,
   output logic        o_valid,
   output logic [31:0] o_inst,
   output logic [31:0] o_pc,
   output logic [31:0] o_pc_next
);

   localparam int AW = $clog2(QUEUE_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C  = CW'(QUEUE_DEPTH);
   localparam logic [31:0]   RESET_PC = {RESET_VECTOR[31:2], 2'b00};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DROP = 2'd2
   } fetch_state_t;

   fetch_state_t state;

   logic [31:0]   fetch_pc;
   logic [31:0]   req_pc;
   logic [31:0]   inst_q [QUEUE_DEPTH];
   logic [31:0]   pc_q   [QUEUE_DEPTH];
   logic [AW-1:0] head;
   logic [AW-1:0] tail;
   logic [CW-1:0] count;

   logic          issue;
   logic          resp_kept;
   logic          push;
   logic          pop;
   logic          q_valid;
   logic          bypass_hit;
   logic          bypass_take;
   logic [CW-1:0] inflight;
   logic          unused_pc_bits;

   assign unused_pc_bits = ^i_redirect_pc[1:0];

   // A request already in flight in WAIT reserves a queue slot, so a push can never overflow.
   always_comb begin
      resp_kept = (state == WAIT) && imem_resp && !i_redirect;
      inflight  = (state == WAIT) ? CW'(1) : '0;
      issue     = !rst && !i_redirect
                  && ((state == IDLE) || imem_resp)
                  && ((count + inflight) < DEPTH_C);
`ifdef IF_QUEUE_BYPASS_EN
      bypass_hit  = resp_kept && (count == '0);
      bypass_take = bypass_hit && !id_stall;
`else
      bypass_hit  = 1'b0;
      bypass_take = 1'b0;
`endif
      q_valid = (count != '0);
      push    = resp_kept && !bypass_take;
      pop     = q_valid && !id_stall && !i_redirect;
   end

   always_comb begin
      imem_addr  = fetch_pc;
      imem_rmask = issue ? 4'hF : 4'h0;
      o_valid    = q_valid || bypass_hit;
      o_inst     = 32'h0;
      o_pc       = 32'h0;
      if (q_valid) begin
         o_inst = inst_q[head];
         o_pc   = pc_q[head];
      end else if (bypass_hit) begin
         o_inst = imem_rdata;
         o_pc   = req_pc;
      end
      o_pc_next = o_valid ? (o_pc + 32'd4) : 32'h0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         fetch_pc <= RESET_PC;
         req_pc   <= RESET_PC;
      end else if (i_redirect) begin
         fetch_pc <= {i_redirect_pc[31:2], 2'b00};
         state    <= ((state != IDLE) && !imem_resp) ? DROP : IDLE;
      end else begin
         if (issue) begin
            fetch_pc <= fetch_pc + 32'd4;
            req_pc   <= fetch_pc;
         end
         case (state)
            IDLE: if (issue) state <= WAIT;
            WAIT,
            DROP: if (imem_resp) state <= issue ? WAIT : IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (i_redirect) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) tail <= tail + AW'(1);
         if (pop)  head <= head + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Entry storage needs no reset; outputs are masked whenever the queue is empty.
   always_ff @(posedge clk) begin
      if (push) begin
         inst_q[tail] <= imem_rdata;
         pc_q[tail]   <= req_pc;
      end
   end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed testbench for if_fetch_queue with a latency-configurable memory model and request/pop monitor.
module tb_if_fetch_queue;

   logic        clk;
   logic        rst;
   logic        i_redirect;
   logic [31:0] i_redirect_pc;
   logic        id_stall;
   logic [31:0] imem_addr;
   logic [3:0]  imem_rmask;
   logic        imem_resp;
   logic [31:0] imem_rdata;
   logic        o_valid;
   logic [31:0] o_inst;
   logic [31:0] o_pc;
   logic [31:0] o_pc_next;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   int          mem_lat = 1;
   logic        mem_busy;
   int          mem_wait;
   logic [31:0] mem_addr;

   logic [31:0] req_addr [$];
   int          req_cyc  [$];
   logic [31:0] pop_pc   [$];
   logic [31:0] pop_inst [$];
   logic [31:0] pop_next [$];
   int          pop_cyc  [$];
   logic [31:0] shown    [$];

   if_fetch_queue #(.RESET_VECTOR(32'h60000000), .QUEUE_DEPTH(4)) dut (
      .clk(clk), .rst(rst),
      .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc), .id_stall(id_stall),
      .imem_addr(imem_addr), .imem_rmask(imem_rmask),
      .imem_resp(imem_resp), .imem_rdata(imem_rdata),
      .o_valid(o_valid), .o_inst(o_inst), .o_pc(o_pc), .o_pc_next(o_pc_next)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h5A5AF00D;
   endfunction

   // Memory: the response strobe is updated first, then the request of this cycle is sampled.
   initial begin
      imem_resp  = 1'b0;
      imem_rdata = 32'h0;
      mem_busy   = 1'b0;
      mem_wait   = 0;
      mem_addr   = 32'h0;
   end

   always @(negedge clk) begin
      if (rst) mem_busy = 1'b0;
      imem_resp  = 1'b0;
      imem_rdata = 32'h0;
      if (mem_busy) begin
         mem_wait = mem_wait - 1;
         if (mem_wait == 0) begin
            imem_resp  = 1'b1;
            imem_rdata = mem_word(mem_addr);
            mem_busy   = 1'b0;
         end
      end
      #1;
      if (!rst && imem_rmask == 4'hF) begin
         mem_busy = 1'b1;
         mem_addr = imem_addr;
         mem_wait = mem_lat;
      end
   end

   always @(negedge clk) begin
      #2;
      cyc = cyc + 1;
      if (!rst) begin
         if (imem_rmask == 4'hF) begin
            req_addr.push_back(imem_addr);
            req_cyc.push_back(cyc);
         end
         if (o_valid) begin
            shown.push_back(o_inst);
            if (!id_stall && !i_redirect) begin
               pop_pc.push_back(o_pc);
               pop_inst.push_back(o_inst);
               pop_next.push_back(o_pc_next);
               pop_cyc.push_back(cyc);
            end
         end
      end
   end

   task automatic clear_logs();
      req_addr.delete(); req_cyc.delete();
      pop_pc.delete(); pop_inst.delete(); pop_next.delete(); pop_cyc.delete();
      shown.delete();
   endtask

   task automatic applyStimulus(input int lat, input logic stall);
      rst        = 1'b1;
      i_redirect = 1'b0;
      id_stall   = stall;
      mem_lat    = lat;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      clear_logs();
   endtask

   task automatic test_reset();
      @(negedge clk); #1;
      checks++; if (imem_rmask !== 4'h0) begin errors++; $display("[TB] FAIL reset_rmask: got %h expected 0", imem_rmask); end
      checks++; if (o_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", o_valid); end
      checks++; if (o_inst !== 32'h0) begin errors++; $display("[TB] FAIL reset_inst: got %h expected 0", o_inst); end
      checks++; if (o_pc !== 32'h0) begin errors++; $display("[TB] FAIL reset_pc: got %h expected 0", o_pc); end
      checks++; if (o_pc_next !== 32'h0) begin errors++; $display("[TB] FAIL reset_pc_next: got %h expected 0", o_pc_next); end
      checks++; if (imem_addr !== 32'h60000000) begin errors++; $display("[TB] FAIL reset_addr: got %h expected 60000000", imem_addr); end
   endtask

   task automatic test_sequential_fetch();
      applyStimulus(1, 1'b0);
      repeat (8) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         checks++; if (req_addr[i] !== 32'h60000000 + 32'(4 * i)) begin errors++; $display("[TB] FAIL seq_req%0d: got %h expected %h", i, req_addr[i], 32'h60000000 + 32'(4 * i)); end
         checks++; if (pop_pc[i] !== 32'h60000000 + 32'(4 * i)) begin errors++; $display("[TB] FAIL seq_pc%0d: got %h expected %h", i, pop_pc[i], 32'h60000000 + 32'(4 * i)); end
         checks++; if (pop_next[i] !== 32'h60000004 + 32'(4 * i)) begin errors++; $display("[TB] FAIL seq_pc_next%0d: got %h expected %h", i, pop_next[i], 32'h60000004 + 32'(4 * i)); end
         checks++; if (pop_inst[i] !== mem_word(32'h60000000 + 32'(4 * i))) begin errors++; $display("[TB] FAIL seq_inst%0d: got %h expected %h", i, pop_inst[i], mem_word(32'h60000000 + 32'(4 * i))); end
      end
      checks++; if (req_cyc[2] - req_cyc[0] !== 2) begin errors++; $display("[TB] FAIL seq_consecutive: got %0d expected 2", req_cyc[2] - req_cyc[0]); end
      checks++; if (pop_cyc[0] - req_cyc[0] !== 2) begin errors++; $display("[TB] FAIL seq_latency: got %0d expected 2", pop_cyc[0] - req_cyc[0]); end
   endtask

   task automatic test_stall_full();
      applyStimulus(1, 1'b1);
      repeat (8) @(negedge clk);
      checks++; if (req_addr.size() !== 4) begin errors++; $display("[TB] FAIL full_req_count: got %0d expected 4", req_addr.size()); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (req_addr[i] !== 32'h60000000 + 32'(4 * i)) begin errors++; $display("[TB] FAIL full_req%0d: got %h expected %h", i, req_addr[i], 32'h60000000 + 32'(4 * i)); end
      end
      #2;
      checks++; if (imem_rmask !== 4'h0) begin errors++; $display("[TB] FAIL full_rmask: got %h expected 0", imem_rmask); end
      checks++; if (o_valid !== 1'b1) begin errors++; $display("[TB] FAIL full_valid: got %b expected 1", o_valid); end
      repeat (3) @(negedge clk); #2;
      checks++; if (o_pc !== 32'h60000000) begin errors++; $display("[TB] FAIL full_hold_pc: got %h expected 60000000", o_pc); end
      checks++; if (o_inst !== mem_word(32'h60000000)) begin errors++; $display("[TB] FAIL full_hold_inst: got %h expected %h", o_inst, mem_word(32'h60000000)); end
      @(negedge clk);
      clear_logs();
      id_stall = 1'b0;
      repeat (10) @(negedge clk);
      checks++; if (req_addr[0] !== 32'h60000010) begin errors++; $display("[TB] FAIL full_resume_req: got %h expected 60000010", req_addr[0]); end
      for (int i = 0; i < 5; i++) begin
         checks++; if (pop_pc[i] !== 32'h60000000 + 32'(4 * i)) begin errors++; $display("[TB] FAIL full_order%0d: got %h expected %h", i, pop_pc[i], 32'h60000000 + 32'(4 * i)); end
      end
   endtask

   task automatic test_redirect_pending();
      applyStimulus(3, 1'b0);
      @(negedge clk);
      i_redirect    = 1'b1;
      i_redirect_pc = 32'h60001003;
      @(negedge clk);
      i_redirect = 1'b0;
      repeat (12) @(negedge clk);
      checks++; if (req_addr[0] !== 32'h60000000) begin errors++; $display("[TB] FAIL rdp_req0: got %h expected 60000000", req_addr[0]); end
      checks++; if (req_addr[1] !== 32'h60001000) begin errors++; $display("[TB] FAIL rdp_req1: got %h expected 60001000", req_addr[1]); end
      checks++; if (req_cyc[1] - req_cyc[0] !== 3) begin errors++; $display("[TB] FAIL rdp_req_gap: got %0d expected 3", req_cyc[1] - req_cyc[0]); end
      checks++; if (pop_pc[0] !== 32'h60001000) begin errors++; $display("[TB] FAIL rdp_first_pc: got %h expected 60001000", pop_pc[0]); end
      checks++; if (pop_inst[0] !== mem_word(32'h60001000)) begin errors++; $display("[TB] FAIL rdp_first_inst: got %h expected %h", pop_inst[0], mem_word(32'h60001000)); end
   endtask

   task automatic test_redirect_same_cycle();
      int hits;
      applyStimulus(2, 1'b0);
      repeat (2) @(negedge clk);
      i_redirect    = 1'b1;
      i_redirect_pc = 32'h60002000;
      @(negedge clk);
      i_redirect = 1'b0;
      repeat (10) @(negedge clk);
      hits = 0;
      foreach (shown[i]) if (shown[i] === mem_word(32'h60000000)) hits++;
      checks++; if (hits !== 0) begin errors++; $display("[TB] FAIL rds_dropped_word_seen: got %0d times expected 0", hits); end
      checks++; if (req_addr[1] !== 32'h60002000) begin errors++; $display("[TB] FAIL rds_req1: got %h expected 60002000", req_addr[1]); end
      checks++; if (req_cyc[1] - req_cyc[0] !== 3) begin errors++; $display("[TB] FAIL rds_req_gap: got %0d expected 3", req_cyc[1] - req_cyc[0]); end
      checks++; if (pop_pc[0] !== 32'h60002000) begin errors++; $display("[TB] FAIL rds_first_pc: got %h expected 60002000", pop_pc[0]); end
   endtask

   task automatic test_async_reset();
      applyStimulus(1, 1'b1);
      repeat (6) @(negedge clk);
      @(posedge clk); #3;
      checks++; if (o_valid !== 1'b1) begin errors++; $display("[TB] FAIL ar_pre_valid: got %b expected 1", o_valid); end
      rst = 1'b1;
      #1;
      checks++; if (o_valid !== 1'b0) begin errors++; $display("[TB] FAIL ar_valid: got %b expected 0", o_valid); end
      checks++; if (o_inst !== 32'h0) begin errors++; $display("[TB] FAIL ar_inst: got %h expected 0", o_inst); end
      checks++; if (o_pc !== 32'h0) begin errors++; $display("[TB] FAIL ar_pc: got %h expected 0", o_pc); end
      checks++; if (o_pc_next !== 32'h0) begin errors++; $display("[TB] FAIL ar_pc_next: got %h expected 0", o_pc_next); end
      checks++; if (imem_rmask !== 4'h0) begin errors++; $display("[TB] FAIL ar_rmask: got %h expected 0", imem_rmask); end
      @(negedge clk);
      rst      = 1'b0;
      id_stall = 1'b0;
      clear_logs();
      repeat (4) @(negedge clk);
      checks++; if (req_addr[0] !== 32'h60000000) begin errors++; $display("[TB] FAIL ar_first_req: got %h expected 60000000", req_addr[0]); end
      checks++; if (pop_pc[0] !== 32'h60000000) begin errors++; $display("[TB] FAIL ar_first_pc: got %h expected 60000000", pop_pc[0]); end
   endtask

   task automatic test_pc_wrap();
      applyStimulus(1, 1'b0);
      repeat (3) @(negedge clk);
      i_redirect    = 1'b1;
      i_redirect_pc = 32'hFFFFFFFC;
      clear_logs();
      @(negedge clk);
      i_redirect = 1'b0;
      #2;
      checks++; if (o_valid !== 1'b0) begin errors++; $display("[TB] FAIL wrap_flush_valid: got %b expected 0", o_valid); end
      repeat (6) @(negedge clk);
      checks++; if (req_addr[0] !== 32'hFFFFFFFC) begin errors++; $display("[TB] FAIL wrap_req0: got %h expected fffffffc", req_addr[0]); end
      checks++; if (req_addr[1] !== 32'h00000000) begin errors++; $display("[TB] FAIL wrap_req1: got %h expected 00000000", req_addr[1]); end
      checks++; if (pop_pc[0] !== 32'hFFFFFFFC) begin errors++; $display("[TB] FAIL wrap_pc0: got %h expected fffffffc", pop_pc[0]); end
      checks++; if (pop_next[0] !== 32'h00000000) begin errors++; $display("[TB] FAIL wrap_pc_next0: got %h expected 00000000", pop_next[0]); end
      checks++; if (pop_pc[1] !== 32'h00000000) begin errors++; $display("[TB] FAIL wrap_pc1: got %h expected 00000000", pop_pc[1]); end
   endtask

   initial begin
      rst           = 1'b1;
      i_redirect    = 1'b0;
      i_redirect_pc = 32'h0;
      id_stall      = 1'b0;
      test_reset();
      test_sequential_fetch();
      test_stall_full();
      test_redirect_pending();
      test_redirect_same_cycle();
      test_async_reset();
      test_pc_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
